// File: rtl/mkmif_arbiter.sv
// Two-port round-robin arbiter in front of a single MKM interface core.
// Serialises single-word reads/writes from two requesters into the core
// read_op/write_op/ready/valid handshake and returns ack/err/rdata to the
// port that owns the transaction. A watchdog aborts stuck transactions.
module mkmif_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        req0,
  input  logic        we0,
  input  logic [10:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  output logic        err0,
  output logic [31:0] rdata0,

  input  logic        req1,
  input  logic        we1,
  input  logic [10:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic        err1,
  output logic [31:0] rdata1,

  output logic        core_read_op,
  output logic        core_write_op,
  output logic [10:0] core_addr,
  output logic [31:0] core_write_data,
  input  logic        core_ready,
  input  logic        core_valid,
  input  logic [31:0] core_read_data,

  output logic        busy,
  output logic        grant
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    ACK       = 3'd4
  } state_t;

  // Watchdog limit widened by one bit so count+1 never wraps before compare.
  localparam logic [16:0] TO_LIMIT   = 17'(TIMEOUT_CYCLES);
  localparam logic        TO_ENABLED = (TIMEOUT_CYCLES != 0);

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        we_q, we_d;
  logic [10:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic [15:0] wdog_q, wdog_d;

  logic        sel;
  logic        timeout_hit;

  // Watchdog expires on the cycle whose increment would reach the limit.
  assign timeout_hit = TO_ENABLED && (({1'b0, wdog_q} + 17'd1) == TO_LIMIT);

  // Next-state, arbitration, latching and watchdog logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    wdog_d       = wdog_q;
    sel          = 1'b0;

    case (state_q)
      IDLE: begin
        if (core_ready && (req0 || req1)) begin
          // On a tie the port that was not served last wins.
          sel          = (req0 && req1) ? ~last_grant_q : req1;
          grant_d      = sel;
          last_grant_d = sel;
          we_d         = sel ? we1    : we0;
          addr_d       = sel ? addr1  : addr0;
          wdata_d      = sel ? wdata1 : wdata0;
          err_d        = 1'b0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        wdog_d  = 16'd0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        wdog_d = wdog_q + 16'd1;
        if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ACK;
          if (!we_q) begin
            if (grant_q) rdata1_d = 32'd0;
            else         rdata0_d = 32'd0;
          end
        end else if (!core_ready) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        wdog_d = wdog_q + 16'd1;
        if (core_ready) begin
          // Normal completion takes precedence over a coincident timeout.
          if (!we_q) begin
            if (grant_q) rdata1_d = core_read_data;
            else         rdata0_d = core_read_data;
            if (!core_valid) err_d = 1'b1;
          end
          state_d = ACK;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ACK;
          if (!we_q) begin
            if (grant_q) rdata1_d = 32'd0;
            else         rdata0_d = 32'd0;
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns everything to idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= 11'd0;
      wdata_q      <= 32'd0;
      err_q        <= 1'b0;
      rdata0_q     <= 32'd0;
      rdata1_q     <= 32'd0;
      wdog_q       <= 16'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      wdog_q       <= wdog_d;
    end
  end

  assign busy            = (state_q != IDLE);
  assign grant           = grant_q;
  assign core_read_op    = (state_q == ISSUE) && !we_q;
  assign core_write_op   = (state_q == ISSUE) &&  we_q;
  assign core_addr       = addr_q;
  assign core_write_data = wdata_q;
  assign ack0            = (state_q == ACK) && !grant_q;
  assign ack1            = (state_q == ACK) &&  grant_q;
  assign err0            = ack0 && err_q;
  assign err1            = ack1 && err_q;
  assign rdata0          = rdata0_q;
  assign rdata1          = rdata1_q;

endmodule

// File: tb/tb_mkmif_arbiter.sv
// Scoreboard bench for mkmif_arbiter with a small behavioural MKM core model.
module tb_mkmif_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0, we0, req1, we1;
  logic [10:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic        core_read_op, core_write_op;
  logic [10:0] core_addr;
  logic [31:0] core_write_data;
  logic        core_ready, core_valid;
  logic [31:0] core_read_data;
  logic        busy, grant;

  always #5 clk = ~clk;

  mkmif_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .core_read_op(core_read_op), .core_write_op(core_write_op),
    .core_addr(core_addr), .core_write_data(core_write_data),
    .core_ready(core_ready), .core_valid(core_valid),
    .core_read_data(core_read_data),
    .busy(busy), .grant(grant)
  );

  typedef struct {
    logic        port;
    logic        we;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          n_ops = 0;
  logic [31:0] exp_rd0 = 32'd0;
  logic [31:0] exp_rd1 = 32'd0;

  // Core model state
  logic [31:0] mem [0:2047];
  logic        m_ready = 1'b1;
  logic        m_valid = 1'b0;
  logic [31:0] m_data = 32'd0;
  logic        m_pend_rd = 1'b0;
  logic [10:0] m_pend_addr = 11'd0;
  int          m_cnt = 0;
  int          m_lat = 3;
  logic        hang = 1'b0;
  logic        gate = 1'b0;
  logic        s_rd, s_wr;
  logic [10:0] s_addr;
  logic [31:0] s_wdata;

  assign core_ready     = m_ready & ~gate;
  assign core_valid     = m_valid;
  assign core_read_data = m_data;

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: goes busy for m_lat cycles after an op; hang keeps it busy.
  always @(posedge clk) begin
    s_rd = core_read_op; s_wr = core_write_op;
    s_addr = core_addr; s_wdata = core_write_data;
    #1;
    if (!reset_n) begin
      m_ready = 1'b1; m_valid = 1'b0; m_cnt = 0; m_data = 32'd0;
    end else if (s_rd || s_wr) begin
      if (s_wr) mem[s_addr] = s_wdata;
      m_ready = 1'b0; m_valid = 1'b0;
      m_pend_rd = s_rd; m_pend_addr = s_addr; m_cnt = m_lat;
    end else if (!m_ready && !hang) begin
      if (m_cnt > 1) m_cnt = m_cnt - 1;
      else begin
        m_ready = 1'b1;
        m_valid = m_pend_rd;
        m_data  = mem[m_pend_addr];
      end
    end
  end

  // Scoreboard monitor: checks every issued op and every ack against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (core_read_op || core_write_op) begin
        n_ops++;
        vectors++;
        if (core_read_op && core_write_op) begin
          miscompares++;
          $display("FAIL both_ops: rd=%b wr=%b, required not both", core_read_op, core_write_op);
        end else if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL op_unexpected: op issued with no pending transaction");
        end else if (core_write_op !== sb[0].we || core_addr !== sb[0].addr ||
                     (sb[0].we && core_write_data !== sb[0].wdata)) begin
          miscompares++;
          $display("FAIL op_fields: wr=%b addr=%h data=%h, required wr=%b addr=%h data=%h",
                   core_write_op, core_addr, core_write_data, sb[0].we, sb[0].addr, sb[0].wdata);
        end
        vectors++;
        if (core_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL op_while_busy: core_ready=%b, required 1", core_ready);
        end
      end
      if (ack0 || ack1) begin
        vectors++;
        if (ack0 && ack1) begin
          miscompares++;
          $display("FAIL both_acks: ack0=%b ack1=%b", ack0, ack1);
        end else if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL ack_unexpected: ack0=%b ack1=%b with empty queue", ack0, ack1);
        end else begin
          e = sb.pop_front();
          if (ack1 !== e.port || grant !== e.port) begin
            miscompares++;
            $display("FAIL ack_port: ack1=%b grant=%b, required port %0d", ack1, grant, e.port);
          end else if ((e.port ? err1 : err0) !== e.err ||
                       (e.port ? err0 : err1) !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_err: err0=%b err1=%b, required err=%b on port %0d",
                     err0, err1, e.err, e.port);
          end else if ((e.port ? rdata1 : rdata0) !== e.rdata) begin
            miscompares++;
            $display("FAIL ack_rdata: got %h, required %h on port %0d",
                     e.port ? rdata1 : rdata0, e.rdata, e.port);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic port, input logic we, input logic [10:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rd, input logic err);
    exp_t e;
    e.port = port; e.we = we; e.addr = addr; e.wdata = wdata; e.err = err;
    if (we) e.rdata = port ? exp_rd1 : exp_rd0;
    else begin
      e.rdata = rd;
      if (port) exp_rd1 = rd; else exp_rd0 = rd;
    end
    sb.push_back(e);
  endtask

  task automatic drive_req(input logic port, input logic on, input logic we,
                           input logic [10:0] addr, input logic [31:0] wdata);
    if (port) begin req1 = on; we1 = we; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = on; we0 = we; addr0 = addr; wdata0 = wdata; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    sb.delete();
    exp_rd0 = 32'd0; exp_rd1 = 32'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One request on one port, waited out to its ack, pulse width checked.
  task automatic run_txn(input logic port, input logic we, input logic [10:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rd, input string name);
    int  ops0;
    bit  got;
    ops0 = n_ops;
    got  = 0;
    push_exp(port, we, addr, wdata, rd, 1'b0);
    @(negedge clk);
    drive_req(port, 1'b1, we, addr, wdata);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if ((port ? ack1 : ack0) === 1'b1) begin got = 1; break; end
    end
    drive_req(port, 1'b0, 1'b0, 11'd0, 32'd0);
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s_ack_timeout: no ack within 60 cycles, required ack on port %0d", name, port);
      sb.delete();
      return;
    end
    vectors++;
    if (n_ops - ops0 !== 1) begin
      miscompares++;
      $display("FAIL %s_op_count: %0d ops, required 1", name, n_ops - ops0);
    end
    @(negedge clk);
    vectors++;
    if ({ack0, ack1} !== 2'b00) begin
      miscompares++;
      $display("FAIL %s_ack_width: ack0=%b ack1=%b one cycle later, required 00", name, ack0, ack1);
    end
  endtask

  task automatic test_reset();
    do_reset();
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({ack0, ack1, err0, err1, busy, grant, core_read_op, core_write_op} !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: %b, required 00000000",
               {ack0, ack1, err0, err1, busy, grant, core_read_op, core_write_op});
    end
    vectors++;
    if (rdata0 !== 32'd0 || rdata1 !== 32'd0 || core_addr !== 11'd0 || core_write_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_data: rdata0=%h rdata1=%h addr=%h wdata=%h, required all 0",
               rdata0, rdata1, core_addr, core_write_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    run_txn(1'b0, 1'b0, 11'h010, 32'd0, 32'hDEADBEEF, "single_read");
  endtask

  task automatic test_single_write();
    run_txn(1'b1, 1'b1, 11'h7FF, 32'h01234567, 32'd0, "single_write");
    vectors++;
    if (grant !== 1'b1) begin
      miscompares++;
      $display("FAIL write_grant: grant=%b, required 1", grant);
    end
    vectors++;
    if (mem[11'h7FF] !== 32'h01234567) begin
      miscompares++;
      $display("FAIL write_mem: core word=%h, required 01234567", mem[11'h7FF]);
    end
  endtask

  task automatic test_contention();
    int acks, ops0;
    do_reset();
    ops0 = n_ops;
    acks = 0;
    push_exp(1'b0, 1'b0, 11'h100, 32'd0, 32'hA5A50100, 1'b0);
    push_exp(1'b1, 1'b1, 11'h200, 32'hCAFE0200, 32'd0, 1'b0);
    push_exp(1'b0, 1'b0, 11'h100, 32'd0, 32'hA5A50100, 1'b0);
    push_exp(1'b1, 1'b1, 11'h200, 32'hCAFE0200, 32'd0, 1'b0);
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b0, 11'h100, 32'd0);
    drive_req(1'b1, 1'b1, 1'b1, 11'h200, 32'hCAFE0200);
    for (int k = 0; k < 200 && acks < 4; k++) begin
      @(negedge clk);
      if (ack0 || ack1) acks++;
    end
    drive_req(1'b0, 1'b0, 1'b0, 11'd0, 32'd0);
    drive_req(1'b1, 1'b0, 1'b0, 11'd0, 32'd0);
    repeat (8) @(negedge clk);
    vectors++;
    if (acks !== 4 || n_ops - ops0 !== 4) begin
      miscompares++;
      $display("FAIL contention_count: acks=%0d ops=%0d, required 4 and 4", acks, n_ops - ops0);
    end
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL contention_drain: %0d transactions unserved, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_core_gated();
    int  ops0;
    bit  bad, got;
    ops0 = n_ops;
    bad  = 0;
    got  = 0;
    gate = 1'b1;
    push_exp(1'b0, 1'b0, 11'h010, 32'd0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b0, 11'h010, 32'd0);
    repeat (6) begin
      @(negedge clk);
      if (busy !== 1'b0) bad = 1;
    end
    vectors++;
    if (bad || n_ops !== ops0) begin
      miscompares++;
      $display("FAIL gated_idle: busy_seen=%b ops=%0d, required 0 and 0", bad, n_ops - ops0);
    end
    gate = 1'b0;
    @(negedge clk);
    vectors++;
    if (core_read_op !== 1'b1 || core_addr !== 11'h010) begin
      miscompares++;
      $display("FAIL gated_issue: read_op=%b addr=%h, required 1 and 010", core_read_op, core_addr);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ack0 === 1'b1) begin got = 1; break; end
    end
    drive_req(1'b0, 1'b0, 1'b0, 11'd0, 32'd0);
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL gated_ack: no ack0 within 40 cycles, required ack0");
      sb.delete();
    end
  endtask

  task automatic test_timeout();
    int  c_op, c_ack;
    bit  got_op, got_ack;
    got_op = 0; got_ack = 0; c_op = 0; c_ack = 0;
    hang = 1'b1;
    push_exp(1'b0, 1'b0, 11'h030, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b0, 11'h030, 32'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (core_read_op === 1'b1) begin got_op = 1; c_op = cyc; break; end
    end
    for (int k = 0; k < 30 && got_op; k++) begin
      @(negedge clk);
      if (ack0 === 1'b1) begin got_ack = 1; c_ack = cyc; break; end
    end
    drive_req(1'b0, 1'b0, 1'b0, 11'd0, 32'd0);
    vectors++;
    if (!got_ack || c_ack - (c_op + 1) !== 8) begin
      miscompares++;
      $display("FAIL timeout_latency: ack %0d cycles after WAIT_BUSY entry (seen=%b), required 8",
               c_ack - (c_op + 1), got_ack);
      sb.delete();
    end
    @(negedge clk);
    hang = 1'b0;
    run_txn(1'b0, 1'b0, 11'h010, 32'd0, 32'hDEADBEEF, "after_timeout");
  endtask

  task automatic test_reset_mid_op();
    bit got_op;
    got_op = 0;
    m_lat = 10;
    push_exp(1'b1, 1'b0, 11'h100, 32'd0, 32'hA5A50100, 1'b0);
    @(negedge clk);
    drive_req(1'b1, 1'b1, 1'b0, 11'h100, 32'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (core_read_op === 1'b1) begin got_op = 1; break; end
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (!got_op || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_setup: op_seen=%b busy=%b, required 1 and 1", got_op, busy);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({ack0, ack1, err0, err1, busy, grant, core_read_op, core_write_op} !== 8'd0 ||
        rdata0 !== 32'd0 || rdata1 !== 32'd0) begin
      miscompares++;
      $display("FAIL midop_reset: ctrl=%b rdata0=%h rdata1=%h, required all 0",
               {ack0, ack1, err0, err1, busy, grant, core_read_op, core_write_op}, rdata0, rdata1);
    end
    sb.delete();
    drive_req(1'b1, 1'b0, 1'b0, 11'd0, 32'd0);
    exp_rd0 = 32'd0; exp_rd1 = 32'd0;
    m_lat = 3;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_txn(1'b1, 1'b0, 11'h010, 32'd0, 32'hDEADBEEF, "after_reset");
  endtask

  initial begin
    mem[11'h010] = 32'hDEADBEEF;
    mem[11'h030] = 32'h30303030;
    mem[11'h100] = 32'hA5A50100;
    reset_n = 1'b0;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_core_gated();
    test_timeout();
    test_reset_mid_op();
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
